// File: rtl/cmd_rx_frame_filter.sv
// cmd_rx_frame_filter: store-and-forward RX filter that forwards only complete, error-free frames addressed to us
module cmd_rx_frame_filter #(
  parameter int ADDR_WIDTH = 11,
  parameter int MIN_FRAME = 14,
  parameter bit ALLOW_BROADCAST = 1'b1
) (
  input  logic        gtx_clk_bufg,
  input  logic        gtx_resetn,
  input  logic [47:0] fpga_mac,
  input  logic [7:0]  s_axis_tdata,
  input  logic        s_axis_tvalid,
  input  logic        s_axis_tlast,
  input  logic        s_axis_tuser,
  output logic        s_axis_tready,
  output logic [7:0]  m_axis_tdata,
  output logic        m_axis_tvalid,
  output logic        m_axis_tlast,
  input  logic        m_axis_tready,
  output logic [15:0] frames_passed,
  output logic [15:0] frames_dropped,
  output logic        drop_pulse
);
  localparam int DEPTH = 1 << ADDR_WIDTH;
  typedef enum logic [1:0] {W_HDR, W_BODY, W_DROP} wstate_t;
  wstate_t state, state_nxt;
  logic [8:0] mem [DEPTH];
  logic [ADDR_WIDTH-1:0] wr_ptr, wr_commit, rd_ptr;
  logic [15:0] len;
  logic [7:0] mac_byte;
  logic is_mac, is_bc, mac_hit, bc_hit, in_hdr, full, long_ok, bad, rd_empty;
  logic wr_en, rewind, commit, drop_now;
  assign in_hdr = state == W_HDR;
  assign mac_byte = 8'(fpga_mac >> {3'd5 - len[2:0], 3'b000});
  assign mac_hit = (len == '0 || is_mac) && s_axis_tdata == mac_byte;
  assign bc_hit = ALLOW_BROADCAST && (len == '0 || is_bc) && s_axis_tdata == 8'hFF;
  assign full = (wr_ptr + 1'b1) == rd_ptr;
  assign long_ok = {16'd0, len} + 32'd1 >= 32'(MIN_FRAME);
  assign bad = full || (in_hdr && (!(mac_hit || bc_hit) || s_axis_tlast)) || (s_axis_tlast && (s_axis_tuser || !long_ok));
  assign rd_empty = rd_ptr == wr_commit;
  // write-side decisions for the current beat: store, rewind, commit or just consume
  always_comb begin
    state_nxt = state;
    wr_en = 1'b0;
    rewind = 1'b0;
    commit = 1'b0;
    drop_now = 1'b0;
    if (s_axis_tvalid && state == W_DROP) begin
      drop_now = s_axis_tlast;
      state_nxt = s_axis_tlast ? W_HDR : W_DROP;
    end else if (s_axis_tvalid) begin
      rewind = bad;
      drop_now = bad && s_axis_tlast;
      wr_en = !bad;
      commit = !bad && s_axis_tlast;
      state_nxt = s_axis_tlast ? W_HDR : bad ? W_DROP : (in_hdr && len[2:0] == 3'd5) ? W_BODY : state;
    end
  end
  // write pointers, header tracking, frame statistics
  always_ff @(posedge gtx_clk_bufg or negedge gtx_resetn)
    if (!gtx_resetn) begin
      state <= W_HDR;
      wr_ptr <= '0;
      wr_commit <= '0;
      len <= '0;
      is_mac <= 1'b0;
      is_bc <= 1'b0;
      s_axis_tready <= 1'b0;
      frames_passed <= '0;
      frames_dropped <= '0;
      drop_pulse <= 1'b0;
    end else begin
      state <= state_nxt;
      s_axis_tready <= 1'b1;
      if (s_axis_tvalid) begin
        len <= s_axis_tlast ? '0 : len + 16'(len != '1);
        is_mac <= mac_hit;
        is_bc <= bc_hit;
      end
      wr_ptr <= rewind ? wr_commit : wr_ptr + ADDR_WIDTH'(wr_en);
      if (commit) wr_commit <= wr_ptr + 1'b1;
      frames_passed <= frames_passed + 16'(commit && !(&frames_passed));
      frames_dropped <= frames_dropped + 16'(drop_now && !(&frames_dropped));
      drop_pulse <= drop_now;
    end
  // frame buffer storage; contents need no reset since pointers define validity
  always_ff @(posedge gtx_clk_bufg)
    if (wr_en) mem[wr_ptr] <= {s_axis_tlast, s_axis_tdata};
  // output register drains only the committed region, holding while stalled
  always_ff @(posedge gtx_clk_bufg or negedge gtx_resetn)
    if (!gtx_resetn) begin
      rd_ptr <= '0;
      m_axis_tvalid <= 1'b0;
      m_axis_tdata <= '0;
      m_axis_tlast <= 1'b0;
    end else if (!m_axis_tvalid || m_axis_tready) begin
      m_axis_tvalid <= !rd_empty;
      if (!rd_empty) begin
        {m_axis_tlast, m_axis_tdata} <= mem[rd_ptr];
        rd_ptr <= rd_ptr + 1'b1;
      end
    end
endmodule

// File: tb/tb_cmd_rx_frame_filter.sv
// tb_cmd_rx_frame_filter: frame-level model checks a default-depth and a 64-entry instance side by side
module tb_cmd_rx_frame_filter;
  localparam logic [47:0] MAC = 48'h5a0102030405;
  localparam logic [47:0] BCAST = 48'hFFFFFFFFFFFF;
  localparam logic [47:0] OTHER = 48'h985aebdb066f;
  logic clk = 1'b0;
  logic rst_n = 1'b1;
  logic [7:0] s_tdata = '0;
  logic s_tvalid = 1'b0, s_tlast = 1'b0, s_tuser = 1'b0, m_tready = 1'b1;
  logic s_tready [2];
  logic [7:0] m_tdata [2];
  logic m_tvalid [2];
  logic m_tlast [2];
  logic [15:0] passed [2];
  logic [15:0] dropped [2];
  logic dpulse [2];
  int n_cmp = 0, n_err = 0;
  logic [8:0] q0 [$];
  logic [8:0] q1 [$];
  int exp_pass [2], exp_drop [2], pulses [2], beats [2], lasts [2];
  logic pv [2];
  logic [8:0] pd [2];
  logic pr = 1'b0;
  logic [8:0] e_c;
  int b0, l0, lat, quiet;

  always #5 clk = ~clk;

  cmd_rx_frame_filter dut0 (
    .gtx_clk_bufg(clk), .gtx_resetn(rst_n), .fpga_mac(MAC),
    .s_axis_tdata(s_tdata), .s_axis_tvalid(s_tvalid), .s_axis_tlast(s_tlast), .s_axis_tuser(s_tuser),
    .s_axis_tready(s_tready[0]), .m_axis_tdata(m_tdata[0]), .m_axis_tvalid(m_tvalid[0]),
    .m_axis_tlast(m_tlast[0]), .m_axis_tready(m_tready), .frames_passed(passed[0]),
    .frames_dropped(dropped[0]), .drop_pulse(dpulse[0])
  );

  cmd_rx_frame_filter #(.ADDR_WIDTH(6)) dut1 (
    .gtx_clk_bufg(clk), .gtx_resetn(rst_n), .fpga_mac(MAC),
    .s_axis_tdata(s_tdata), .s_axis_tvalid(s_tvalid), .s_axis_tlast(s_tlast), .s_axis_tuser(s_tuser),
    .s_axis_tready(s_tready[1]), .m_axis_tdata(m_tdata[1]), .m_axis_tvalid(m_tvalid[1]),
    .m_axis_tlast(m_tlast[1]), .m_axis_tready(m_tready), .frames_passed(passed[1]),
    .frames_dropped(dropped[1]), .drop_pulse(dpulse[1])
  );

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, required %0h", nm, act, exp);
    end
  endtask

  // per-cycle compare: every transferred byte against the model queue, plus hold-while-stalled
  always @(negedge clk) begin
    if (!rst_n) begin
      pulses[0] = 0;
      pulses[1] = 0;
      pv[0] = 1'b0;
      pv[1] = 1'b0;
    end else begin
      for (int i = 0; i < 2; i++) begin
        if (pv[i] && !pr) begin
          check($sformatf("hold_valid%0d", i), 32'(m_tvalid[i]), 32'd1);
          check($sformatf("hold_data%0d", i), 32'({m_tlast[i], m_tdata[i]}), 32'(pd[i]));
        end
        if (m_tvalid[i] && m_tready) begin
          beats[i]++;
          if (m_tlast[i]) lasts[i]++;
          if ((i == 0 && q0.size() == 0) || (i == 1 && q1.size() == 0)) begin
            n_cmp++;
            n_err++;
            $display("FAIL beat%0d: got unexpected byte %02h, required no output", i, m_tdata[i]);
          end else begin
            if (i == 0) e_c = q0.pop_front();
            else e_c = q1.pop_front();
            check($sformatf("beat%0d", i), 32'({m_tlast[i], m_tdata[i]}), 32'(e_c));
          end
        end
        if (dpulse[i]) pulses[i]++;
        pv[i] = m_tvalid[i];
        pd[i] = {m_tlast[i], m_tdata[i]};
      end
      pr = m_tready;
    end
  end

  // model decides the fate of the whole frame at its start, then the frame is driven
  task automatic send(input logic [47:0] dst, input int len, input bit tu, input int seed);
    logic [7:0] b [$];
    int p, depth, cap;
    bit ok;
    b = {};
    for (int k = 0; k < len; k++) b.push_back(k < 6 ? dst[47-8*k -: 8] : 8'(seed + 3 * k));
    for (int i = 0; i < 2; i++) begin
      p = i == 0 ? q0.size() : q1.size();
      depth = i == 0 ? 2048 : 64;
      cap = p > 0 ? depth - p : depth - 1;
      ok = len >= 6 && (dst == MAC || dst == BCAST) && len >= 14 && !tu && len <= cap;
      if (ok) begin
        exp_pass[i]++;
        for (int k = 0; k < len; k++)
          if (i == 0) q0.push_back({k == len - 1, b[k]});
          else q1.push_back({k == len - 1, b[k]});
      end else exp_drop[i]++;
    end
    for (int k = 0; k < len; k++) begin
      if (k % 11 == 7) begin
        @(posedge clk); #2;
        s_tvalid = 1'b0;
      end
      @(posedge clk); #2;
      s_tvalid = 1'b1;
      s_tdata = b[k];
      s_tlast = k == len - 1;
      s_tuser = (k == len - 1) ? tu : (k % 5 == 1);
    end
    @(posedge clk); #2;
    s_tvalid = 1'b0;
    s_tlast = 1'b0;
    s_tuser = 1'b0;
  endtask

  task automatic drain(input int lim);
    int c;
    c = 0;
    while ((q0.size() != 0 || q1.size() != 0) && c < lim) begin
      @(negedge clk);
      c++;
    end
    check("drain_empty", 32'(q0.size() + q1.size()), 32'd0);
    repeat (4) @(negedge clk);
  endtask

  task automatic check_ctrs(input string tag);
    for (int i = 0; i < 2; i++) begin
      check($sformatf("%s_passed%0d", tag, i), 32'(passed[i]), 32'(exp_pass[i]));
      check($sformatf("%s_dropped%0d", tag, i), 32'(dropped[i]), 32'(exp_drop[i]));
      check($sformatf("%s_pulses%0d", tag, i), 32'(pulses[i]), 32'(exp_drop[i]));
    end
  endtask

  initial begin
    #1 rst_n = 1'b0;
    #11;
    for (int i = 0; i < 2; i++) begin
      check($sformatf("rst_tready%0d", i), 32'(s_tready[i]), 32'd0);
      check($sformatf("rst_tvalid%0d", i), 32'(m_tvalid[i]), 32'd0);
      check($sformatf("rst_tdata%0d", i), 32'({m_tlast[i], m_tdata[i]}), 32'd0);
      check($sformatf("rst_ctrs%0d", i), {passed[i], dropped[i]}, 32'd0);
      check($sformatf("rst_pulse%0d", i), 32'(dpulse[i]), 32'd0);
    end
    repeat (2) @(posedge clk);
    #2 rst_n = 1'b1;
    repeat (2) @(posedge clk);
    #1 check("tready_after_rst", 32'(s_tready[0]), 32'd1);

    b0 = beats[0];
    l0 = lasts[0];
    send(MAC, 38, 1'b0, 1);
    lat = 0;
    for (int c = 1; c <= 4; c++) begin
      @(posedge clk); #1;
      if (m_tvalid[0]) begin
        lat = c;
        break;
      end
    end
    check("latency_le3", 32'(lat >= 1 && lat <= 3), 32'd1);
    drain(400);
    check("good_beats", 32'(beats[0] - b0), 32'd38);
    check("good_lasts", 32'(lasts[0] - l0), 32'd1);
    check("good_passed_lit", 32'(passed[0]), 32'd1);
    check_ctrs("good");

    b0 = beats[0];
    send(OTHER, 38, 1'b0, 2);
    drain(400);
    check("bad_dest_beats", 32'(beats[0] - b0), 32'd0);
    check("bad_dest_dropped_lit", 32'(dropped[0]), 32'd1);
    check_ctrs("bad_dest");

    b0 = beats[0];
    send(MAC, 38, 1'b1, 3);
    send(MAC, 38, 1'b0, 4);
    drain(400);
    check("tuser_beats", 32'(beats[0] - b0), 32'd38);
    check("tuser_ctrs_lit", {passed[0], dropped[0]}, {16'd2, 16'd2});
    check_ctrs("tuser");

    send(48'h5a01FF000000, 3, 1'b0, 5);
    send(MAC, 5, 1'b0, 6);
    send(MAC, 13, 1'b0, 7);
    send(MAC, 14, 1'b0, 8);
    send(BCAST, 20, 1'b0, 9);
    send(48'h5aFFFFFFFFFF, 20, 1'b0, 10);
    drain(400);
    check("edges_ctrs_lit", {passed[0], dropped[0]}, {16'd4, 16'd6});
    check_ctrs("edges");

    @(posedge clk); #2 m_tready = 1'b0;
    send(MAC, 38, 1'b0, 11);
    send(MAC, 38, 1'b0, 12);
    repeat (120) @(posedge clk);
    #1 check("stall_head", 32'({m_tvalid[0], m_tdata[0]}), 32'h15a);
    @(posedge clk); #2 m_tready = 1'b1;
    for (int k = 0; k < 76; k++) begin
      @(negedge clk);
      check("contig_valid", 32'(m_tvalid[0]), 32'd1);
    end
    drain(400);
    check_ctrs("stall");

    b0 = beats[1];
    send(MAC, 80, 1'b0, 13);
    send(MAC, 20, 1'b0, 14);
    send(BCAST, 10, 1'b0, 15);
    drain(400);
    check("small_beats", 32'(beats[1] - b0), 32'd20);
    check_ctrs("small");

    send(MAC, 38, 1'b0, 21);
    lat = 0;
    for (int c = 0; c < 10 && !lat; c++) begin
      @(posedge clk); #1;
      if (m_tvalid[0]) lat = 1;
    end
    check("mid_output_seen", 32'(lat), 32'd1);
    repeat (5) @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("rst_mid_tvalid0", 32'(m_tvalid[0]), 32'd0);
    check("rst_mid_tvalid1", 32'(m_tvalid[1]), 32'd0);
    q0.delete();
    q1.delete();
    for (int i = 0; i < 2; i++) begin
      exp_pass[i] = 0;
      exp_drop[i] = 0;
    end
    repeat (3) @(posedge clk);
    #2 rst_n = 1'b1;
    quiet = 0;
    repeat (30) begin
      @(negedge clk);
      if (m_tvalid[0] || m_tvalid[1]) quiet++;
    end
    check("post_rst_quiet", 32'(quiet), 32'd0);
    b0 = beats[0];
    send(MAC, 20, 1'b0, 22);
    drain(400);
    check("post_rst_beats", 32'(beats[0] - b0), 32'd20);
    check_ctrs("post_rst");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not complete in time");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err + 1);
    $fatal(1);
  end
endmodule
